fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Keeps a single instruction-memory request in
// flight, buffers returned words in a 2-entry {pc, instruction} FIFO and
// presents the FIFO head to the datapath with a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at a new word address; a
// request that is still outstanding at redirect time is drained and dropped.
//
// Parameters
//   RESET_PC       first fetch address after reset (word-aligned)
//
// Ports
//   clk            clock, all state updates on rising edge
//   rst            synchronous active-high reset
//   redirect       one-cycle pulse: flush and refetch from redirect_pc
//   redirect_pc    new fetch address (bits [1:0] ignored)
//   imem_req       registered memory request
//   imem_addr      registered, word-aligned request address
//   imem_ack       memory returns imem_rdata for the current request
//   imem_rdata     returned instruction word
//   inst_valid     FIFO head holds an instruction
//   inst_ready     datapath accepts the head this cycle
//   inst_out       head instruction word
//   inst_pc        head instruction address
//   inst_pc_plus4  head address + 4 (mod 2^32)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no request outstanding
    WAIT  = 2'd1,  // request outstanding, result will be kept
    DRAIN = 2'd2   // request outstanding, result will be discarded
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;   // FIFO head
  logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;   // FIFO second entry

  logic        head_valid;
  logic        pop;
  logic        push;
  logic [1:0]  cnt_after_pop;
  logic [31:0] redirect_pc_w;
  logic [31:0] addr_plus4;

  assign head_valid    = (cnt_q != 2'd0);
  assign pop           = head_valid && inst_ready;
  assign cnt_after_pop = cnt_q - {1'b0, pop};
  assign redirect_pc_w = redirect_pc & ~32'h3;
  assign addr_plus4    = addr_q + 32'd4;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!redirect && (cnt_after_pop < 2'd2)) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end

      WAIT: begin
        if (redirect) begin
          if (imem_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = addr_plus4;
          // Room remains after this push only if the FIFO is empty once the
          // concurrent pop is taken into account.
          if (cnt_after_pop == 2'd0) begin
            addr_d = addr_plus4;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end

      DRAIN: begin
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Latest redirect target wins, whatever state we are in.
    if (redirect) begin
      fetch_pc_d = redirect_pc_w;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO, head always in entry 0
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    pc0_d   = pc0_q;
    inst0_d = inst0_q;
    pc1_d   = pc1_q;
    inst1_d = inst1_q;

    if (redirect) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            pc0_d   = addr_q;
            inst0_d = imem_rdata;
          end else begin
            pc1_d   = addr_q;
            inst1_d = imem_rdata;
          end
        end
        2'b01: begin
          cnt_d   = cnt_q - 2'd1;
          pc0_d   = pc1_q;
          inst0_d = inst1_q;
        end
        2'b11: begin
          // Count unchanged; new word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            pc0_d   = addr_q;
            inst0_d = imem_rdata;
          end else begin
            pc0_d   = pc1_q;
            inst0_d = inst1_q;
            pc1_d   = addr_q;
            inst1_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC_W;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC_W;
      cnt_q      <= 2'd0;
      pc0_q      <= '0;
      inst0_q    <= '0;
      pc1_q      <= '0;
      inst1_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      pc0_q      <= pc0_d;
      inst0_q    <= inst0_d;
      pc1_q      <= pc1_d;
      inst1_q    <= inst1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head fields read as zero while empty or held in reset
  // ---------------------------------------------------------------------------
  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign inst_valid    = head_valid && !rst;
  assign inst_out      = inst_valid ? inst0_q : '0;
  assign inst_pc       = inst_valid ? pc0_q : '0;
  assign inst_pc_plus4 = inst_valid ? (pc0_q + 32'd4) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .inst_pc_plus4(inst_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address a is a ^ DEADBEEF.
  function automatic logic [31:0] dw(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chkd;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = r; v.redir = rd; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.ready = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.chkd   = e_valid || r;
    v.e_pc   = e_valid ? e_pc : 32'h0;
    v.e_inst = e_valid ? dw(e_pc) : 32'h0;
    v.e_pc4  = e_valid ? e_pc + 32'd4 : 32'h0;
    return v;
  endfunction

  localparam int NV = 27;
  vec_t tbl [NV];

  // Redirect to start_pc (with the outstanding request, if any, acked and
  // dropped), then stream for ncyc cycles with the given ack/ready patterns,
  // checking every accepted instruction is the next sequential one.
  task automatic stream(input string name, input logic [31:0] start_pc, input int ncyc,
                        input int ack_mod, input int rdy_mod, output int pops);
    logic [31:0] exp_pc;
    logic        rdy;
    logic        ackv;
    pops   = 0;
    exp_pc = start_pc;
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = start_pc;
    inst_ready  = 1'b0;
    imem_ack    = imem_req;
    imem_rdata  = 32'h0BAD_0BAD;
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      redirect   = 1'b0;
      rdy        = (c % rdy_mod) != 1;
      ackv       = imem_req && ((c % ack_mod) == 0);
      inst_ready = rdy;
      imem_ack   = ackv;
      imem_rdata = ackv ? dw(imem_addr) : 32'h0BAD_0BAD;
      if (inst_valid && rdy) begin
        chk({name, ".pc"},   inst_pc, exp_pc);
        chk({name, ".inst"}, inst_out, dw(exp_pc));
        chk({name, ".pc4"},  inst_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
  endtask

  initial begin
    int pops;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

    //             rst rd rpc            ack rdata             rdy  req addr           vld pc
    tbl[0]  = mk(1, 0, 32'h0,          0, 32'h0,            0,   0, 32'h0,          0, 32'h0);
    tbl[1]  = mk(1, 0, 32'h0,          1, dw(32'h40),       0,   0, 32'h0,          0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,          0, 32'h0,            1,   1, 32'h0,          0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,          1, dw(32'h0),        1,   1, 32'h4,          1, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,          1, dw(32'h4),        1,   1, 32'h8,          1, 32'h4);
    tbl[5]  = mk(0, 0, 32'h0,          1, dw(32'h8),        1,   1, 32'hC,          1, 32'h8);
    tbl[6]  = mk(0, 0, 32'h0,          1, dw(32'hC),        0,   0, 32'hC,          1, 32'h8);
    tbl[7]  = mk(0, 0, 32'h0,          0, 32'h0,            0,   0, 32'hC,          1, 32'h8);
    tbl[8]  = mk(0, 0, 32'h0,          0, 32'h0,            1,   1, 32'h10,         1, 32'hC);
    tbl[9]  = mk(0, 0, 32'h0,          1, dw(32'h10),       1,   1, 32'h14,         1, 32'h10);
    tbl[10] = mk(0, 0, 32'h0,          0, 32'h0,            1,   1, 32'h14,         0, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,          1, dw(32'h14),       1,   1, 32'h18,         1, 32'h14);
    tbl[12] = mk(0, 1, 32'h103,        0, 32'h0,            0,   1, 32'h18,         0, 32'h0);
    tbl[13] = mk(0, 0, 32'h0,          0, 32'h0,            0,   1, 32'h18,         0, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,          0, 32'h0,            0,   1, 32'h18,         0, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,          1, dw(32'h18),       0,   0, 32'h18,         0, 32'h0);
    tbl[16] = mk(0, 0, 32'h0,          0, 32'h0,            0,   1, 32'h100,        0, 32'h0);
    tbl[17] = mk(0, 0, 32'h0,          1, dw(32'h100),      0,   1, 32'h104,        1, 32'h100);
    tbl[18] = mk(0, 0, 32'h0,          1, dw(32'h104),      0,   0, 32'h104,        1, 32'h100);
    tbl[19] = mk(0, 1, 32'h200,        1, 32'h1234_5678,    1,   0, 32'h104,        0, 32'h0);
    tbl[20] = mk(0, 0, 32'h0,          0, 32'h0,            0,   1, 32'h200,        0, 32'h0);
    tbl[21] = mk(0, 1, 32'hFFFF_FFFE,  1, dw(32'h200),      1,   0, 32'h200,        0, 32'h0);
    tbl[22] = mk(0, 0, 32'h0,          0, 32'h0,            0,   1, 32'hFFFF_FFFC,  0, 32'h0);
    tbl[23] = mk(0, 0, 32'h0,          1, dw(32'hFFFF_FFFC),0,   1, 32'h0,          1, 32'hFFFF_FFFC);
    tbl[24] = mk(0, 0, 32'h0,          1, dw(32'h0),        1,   1, 32'h4,          1, 32'h0);
    tbl[25] = mk(1, 0, 32'h0,          1, dw(32'h4),        0,   0, 32'h0,          0, 32'h0);
    tbl[26] = mk(0, 0, 32'h0,          0, 32'h0,            0,   1, 32'h0,          0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst         = tbl[i].rst;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      imem_ack    = tbl[i].ack;
      imem_rdata  = tbl[i].rdata;
      inst_ready  = tbl[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.req", i),   {31'b0, imem_req},   {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d.addr", i),  imem_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d.valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].chkd) begin
        chk($sformatf("v%0d.inst", i), inst_out,      tbl[i].e_inst);
        chk($sformatf("v%0d.pc", i),   inst_pc,       tbl[i].e_pc);
        chk($sformatf("v%0d.pc4", i),  inst_pc_plus4, tbl[i].e_pc4);
      end
    end

    // Full rate: after the 2-cycle restart latency, one instruction per cycle.
    stream("full", 32'h0000_0400, 20, 1, 1, pops);
    chk("full.pops", pops, 32'd18);

    // Sparse acks and stalling consumer: order kept, progress made.
    stream("sparse", 32'h0000_1000, 60, 2, 3, pops);
    n_cmp++;
    if (pops < 8) begin
      n_err++;
      $display("FAIL sparse.progress: got %0d pops expected at least 8", pops);
    end

    // Address wrap at the top of memory.
    stream("wrap", 32'hFFFF_FFF0, 8, 1, 1, pops);
    chk("wrap.pops", pops, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
